// File: rtl/regfile_32x64.sv
// 32-entry register file with two combinational read ports, one write port and a hardwired zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports (write-before-read).
module regfile_32x64 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [NUM_REGS-1:0] wr_dec;
  logic [NUM_REGS-1:0] reg_en;
  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin : write_decode
    wr_dec = '0;
    if (RegWrite) begin
      wr_dec[WriteRegister] = 1'b1;
    end
    reg_en           = wr_dec;
    reg_en[ZERO_IDX] = 1'b0;
  end

  // An unselected register recirculates its own value, so WriteData is never
  // observed by it; garbage on WriteData with RegWrite low cannot leak in.
  always_comb begin : next_state
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = reg_en[i] ? WriteData : regs_q[i];
    end
    regs_d[ZERO_IDX] = '0;
  end

  // NOTE: the whole array is cleared by reset because every entry must read
  // zero immediately; state is updated only with non-blocking assignments so
  // all 32 flops sample regs_d from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge reset) begin : storage
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin : read_mux
    ReadData1 = regs_q[ReadRegister1];
    ReadData2 = regs_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (WriteRegister != ZERO_IDX)) begin
      if (ReadRegister1 == WriteRegister) begin
        ReadData1 = WriteData;
      end
      if (ReadRegister2 == WriteRegister) begin
        ReadData2 = WriteData;
      end
    end
`endif
    if (ReadRegister1 == ZERO_IDX) begin
      ReadData1 = '0;
    end
    if (ReadRegister2 == ZERO_IDX) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed steps plus a random regression
// against a reference array, with expected read values queued in a scoreboard.
module tb_regfile_32x64;

  localparam int WIDTH    = 64;
  localparam int ZERO_REG = 31;
  localparam logic [WIDTH-1:0] SWEEP_STEP = 64'h0101_0101_0101_0101;
  localparam logic [WIDTH-1:0] ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mdl [32];

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
  } exp_t;

  exp_t sb_q [$];

  regfile_32x64 #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not complete within 1 ms");
    $fatal(1, "watchdog expired");
  end

  // Expected read value given the current write-port inputs and the model.
  function automatic logic [WIDTH-1:0] model_read(input logic [4:0] addr);
    if (addr == 5'(ZERO_REG)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite === 1'b1 && addr == WriteRegister) return WriteData;
`endif
    return mdl[addr];
  endfunction

  task automatic push_exp(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
    exp_t e;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
    e.tag = tag;
    e.e1  = e1;
    e.e2  = e2;
    sb_q.push_back(e);
  endtask

  task automatic check_reads();
    exp_t e;
    #1;
    e = sb_q.pop_front();
    n_checks++;
    assert (ReadData1 === e.e1) else begin
      n_errors++;
      $error("FAIL %s port1: observed %h expected %h", e.tag, ReadData1, e.e1);
    end
    n_checks++;
    assert (ReadData2 === e.e2) else begin
      n_errors++;
      $error("FAIL %s port2: observed %h expected %h", e.tag, ReadData2, e.e2);
    end
  endtask

  task automatic model_check(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    push_exp(tag, r1, r2, model_read(r1), model_read(r2));
    check_reads();
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [WIDTH-1:0] data);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    if (addr != 5'(ZERO_REG)) mdl[addr] = data;
  endtask

  initial begin : stimulus
    logic [4:0] r1;
    logic [4:0] r2;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // Reset state
    #12;
    push_exp("reset_state", 5'd0, 5'd30, '0, '0);
    check_reads();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill everything with ones, then assert reset mid-cycle
    for (int i = 0; i < 32; i++) write_reg(5'(i), ALL_ONES);
    push_exp("all_ones", 5'd3, 5'd31, ALL_ONES, '0);
    check_reads();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    push_exp("reset_async", 5'd3, 5'd17, '0, '0);
    check_reads();

    // Write coincident with reset is lost; first edge after release is accepted
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 64'h0BAD_F00D_0000_0009;
    @(posedge clk);
    #1;
    push_exp("write_in_reset", 5'd9, 5'd9, '0, '0);
    check_reads();
    @(negedge clk);
    reset = 1'b0;
    model_check("pre_first_write", 5'd9, 5'd0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    mdl[9]   = 64'h0BAD_F00D_0000_0009;
    push_exp("first_write", 5'd9, 5'd0, 64'h0BAD_F00D_0000_0009, '0);
    check_reads();

    // Write/read sweep
    for (int i = 0; i < 31; i++) write_reg(5'(i), 64'(i) * SWEEP_STEP);
    for (int i = 0; i < 31; i++) begin
      push_exp("sweep", 5'(i), 5'(30 - i), 64'(i) * SWEEP_STEP, 64'(30 - i) * SWEEP_STEP);
      check_reads();
    end
    push_exp("sweep_zero", 5'd31, 5'd31, '0, '0);
    check_reads();

    // Zero register: no bypass before the edge, nothing stored after it
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'hDEAD_BEEF_0000_0001;
    push_exp("zero_reg_pre", 5'd31, 5'd31, '0, '0);
    check_reads();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    push_exp("zero_reg_post", 5'd31, 5'd30, '0, 64'd30 * SWEEP_STEP);
    check_reads();

    // Write disabled holds the register, including with unknown write data
    write_reg(5'd5, 64'hAAAA);
    RegWrite      = 1'b0;
    WriteRegister = 5'd5;
    WriteData     = 64'h1234;
    repeat (10) @(posedge clk);
    #1;
    push_exp("write_disabled", 5'd5, 5'd5, 64'hAAAA, 64'hAAAA);
    check_reads();
    WriteData = 'x;
    repeat (3) @(posedge clk);
    #1;
    push_exp("x_data_hold", 5'd5, 5'd4, 64'hAAAA, 64'd4 * SWEEP_STEP);
    check_reads();

    // Same-cycle read of the write target
    write_reg(5'd7, 64'h11);
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'h22;
`ifdef REGFILE_BYPASS_EN
    push_exp("same_cycle_pre", 5'd7, 5'd6, 64'h22, 64'd6 * SWEEP_STEP);
`else
    push_exp("same_cycle_pre", 5'd7, 5'd6, 64'h11, 64'd6 * SWEEP_STEP);
`endif
    check_reads();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    mdl[7]   = 64'h22;
    push_exp("same_cycle_post", 5'd7, 5'd7, 64'h22, 64'h22);
    check_reads();

    // Random regression against the reference array
    for (int n = 0; n < 10000; n++) begin
      RegWrite      = 1'($urandom_range(0, 1));
      WriteRegister = 5'($urandom);
      if (RegWrite || $urandom_range(0, 7) != 0) WriteData = {$urandom, $urandom};
      else WriteData = 'x;
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) r1 = WriteRegister;
      if ($urandom_range(0, 3) == 0) r2 = WriteRegister;
      model_check("random", r1, r2);
      @(posedge clk);
      #1;
      if (RegWrite && WriteRegister != 5'(ZERO_REG)) mdl[WriteRegister] = WriteData;
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) model_check("random_final", 5'(i), 5'(31 - i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
